// File: rtl/power_est_pkg.sv
// Shared types and constants for the power-estimation window controller.
package power_est_pkg;

    localparam int CNT_W      = 32;
    localparam int EST_W      = 64;
    localparam int SETTLE_LEN = 2;
    localparam int HYST_SHIFT = 3;
    localparam int SETTLE_W   = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SETTLE,
        REPORT
    } win_state_t;

    // Throttle releases only once the estimate drops a budget/8 margin below the budget.
    function automatic logic throttle_release(input logic [EST_W-1:0] estimate,
                                              input logic [EST_W-1:0] budget);
        return estimate <= (budget - (budget >> HYST_SHIFT));
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating activity counter: synchronous clear wins over increment, sticks at all-ones.
module sat_event_counter
    import power_est_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/power_window_ctrl.sv
// Windowed activity counter / power report controller.
// Optional hysteretic throttle output enabled by defining POWER_THROTTLE_EN.
module power_window_ctrl
    import power_est_pkg::*;
#(
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic             fsm_transition_evt,
    input  logic             pcwrite_toggle_evt,
    input  logic             recovery_cycle_evt,
    output logic [CNT_W-1:0] fsm_transition_count,
    output logic [CNT_W-1:0] pcwrite_toggle_count,
    output logic [CNT_W-1:0] recovery_cycle_count,
    input  logic [EST_W-1:0] power_estimate,
    input  logic [EST_W-1:0] budget,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [EST_W-1:0] rpt_estimate,
    output logic             rpt_over,
    output logic             throttle
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_LEN - 1);

    win_state_t          state;
    win_state_t          state_next;
    logic [WIN_W-1:0]    win_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                start_window;
    logic                count_en;
    logic                capture;
    logic                settle_done;

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign rpt_valid   = (state == REPORT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // enable is only looked at when a window could start, so dropping it mid-window
    // lets the current report finish.
    always_comb begin
        state_next   = state;
        start_window = 1'b0;
        count_en     = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    start_window = 1'b1;
                    state_next   = ACCUM;
                end
            end
            ACCUM: begin
                count_en = 1'b1;
                if (win_cnt <= WIN_W'(1)) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    capture    = 1'b1;
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    if (enable) begin
                        start_window = 1'b1;
                        state_next   = ACCUM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Settle waits out the estimator's register stage before the estimate is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt      <= '0;
            settle_cnt   <= '0;
            rpt_estimate <= '0;
            rpt_over     <= 1'b0;
        end else begin
            if (start_window) begin
                win_cnt <= (window_len == '0) ? WIN_W'(1) : window_len;
            end else if (count_en) begin
                win_cnt <= win_cnt - 1'b1;
            end

            if (state != SETTLE) begin
                settle_cnt <= '0;
            end else if (!settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            if (capture) begin
                rpt_estimate <= power_estimate;
                rpt_over     <= (power_estimate > budget);
            end
        end
    end

    sat_event_counter u_fsm_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_window),
        .inc   (count_en & fsm_transition_evt),
        .count (fsm_transition_count)
    );

    sat_event_counter u_pcw_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_window),
        .inc   (count_en & pcwrite_toggle_evt),
        .count (pcwrite_toggle_count)
    );

    sat_event_counter u_rec_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_window),
        .inc   (count_en & recovery_cycle_evt),
        .count (recovery_cycle_count)
    );

`ifdef POWER_THROTTLE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            throttle <= 1'b0;
        end else if (capture) begin
            if (power_estimate > budget) begin
                throttle <= 1'b1;
            end else if (throttle_release(power_estimate, budget)) begin
                throttle <= 1'b0;
            end
        end
    end
`else
    assign throttle = 1'b0;
`endif

endmodule

// File: tb/tb_power_window_ctrl.sv
// Self-checking bench for power_window_ctrl: table of windows plus stall/reset sequences.
module tb_power_window_ctrl;

    typedef struct {
        logic [15:0] win;
        logic [2:0]  mask;
        logic        weights;
        logic [63:0] est;
        logic [63:0] budget;
        logic [31:0] e_fsm;
        logic [31:0] e_pcw;
        logic [31:0] e_rec;
        logic [63:0] e_est;
        logic        e_over;
        logic        e_thr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rpt_ready;
    logic [15:0] window_len;
    logic [2:0]  evts;
    logic [31:0] fsm_transition_count;
    logic [31:0] pcwrite_toggle_count;
    logic [31:0] recovery_cycle_count;
    logic [63:0] power_estimate;
    logic [63:0] budget;
    logic        rpt_valid;
    logic [63:0] rpt_estimate;
    logic        rpt_over;
    logic        throttle;

    logic        use_weights;
    logic [63:0] fixed_est;
    int          n_checks = 0;
    int          n_fail   = 0;

    vec_t vecs [8];

    power_window_ctrl #(.WIN_W(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .window_len           (window_len),
        .fsm_transition_evt   (evts[0]),
        .pcwrite_toggle_evt   (evts[1]),
        .recovery_cycle_evt   (evts[2]),
        .fsm_transition_count (fsm_transition_count),
        .pcwrite_toggle_count (pcwrite_toggle_count),
        .recovery_cycle_count (recovery_cycle_count),
        .power_estimate       (power_estimate),
        .budget               (budget),
        .rpt_valid            (rpt_valid),
        .rpt_ready            (rpt_ready),
        .rpt_estimate         (rpt_estimate),
        .rpt_over             (rpt_over),
        .throttle             (throttle)
    );

    always #5 clk = ~clk;

    // Environment estimator: one register stage behind the counts, weights 1/2/3.
    always @(posedge clk) begin
        if (use_weights)
            power_estimate <= 64'(fsm_transition_count) + 64'd2 * 64'(pcwrite_toggle_count)
                              + 64'd3 * 64'(recovery_cycle_count);
        else
            power_estimate <= fixed_est;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Starts one window from IDLE, drops enable right after the load, returns cycles to rpt_valid.
    task automatic applyStimulus(input vec_t v, input logic ready_level, output int lat);
        window_len  = v.win;
        evts        = v.mask;
        budget      = v.budget;
        fixed_est   = v.est;
        use_weights = v.weights;
        rpt_ready   = ready_level;
        enable      = 1'b1;
        tick();
        enable = 1'b0;
        lat    = 1;
        while (!rpt_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " rpt_valid"}, 64'(rpt_valid), 64'd0);
        checkOutput({tag, " rpt_estimate"}, rpt_estimate, 64'd0);
        checkOutput({tag, " rpt_over"}, 64'(rpt_over), 64'd0);
        checkOutput({tag, " throttle"}, 64'(throttle), 64'd0);
        checkOutput({tag, " fsm_count"}, 64'(fsm_transition_count), 64'd0);
        checkOutput({tag, " pcw_count"}, 64'(pcwrite_toggle_count), 64'd0);
        checkOutput({tag, " rec_count"}, 64'(recovery_cycle_count), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   lat;
        int   exp_lat;
        int   seen;
        logic exp_thr;
        vec_t s;

        reset       = 1'b1;
        enable      = 1'b0;
        rpt_ready   = 1'b0;
        evts        = 3'b000;
        window_len  = '0;
        budget      = '0;
        fixed_est   = '0;
        use_weights = 1'b0;

        //          win    mask    wt    est                    budget                 fsm    pcw    rec    e_est                  over  thr
        vecs[0] = '{16'd8, 3'b001, 1'b0, 64'd50,                64'd100,               32'd8, 32'd0, 32'd0, 64'd50,                1'b0, 1'b0};
        vecs[1] = '{16'd4, 3'b111, 1'b1, 64'd0,                 64'd100,               32'd4, 32'd4, 32'd4, 64'd24,                1'b0, 1'b0};
        vecs[2] = '{16'd0, 3'b010, 1'b0, 64'd5,                 64'd0,                 32'd0, 32'd1, 32'd0, 64'd5,                 1'b1, 1'b1};
        vecs[3] = '{16'd3, 3'b100, 1'b0, 64'd120,               64'd100,               32'd0, 32'd0, 32'd3, 64'd120,               1'b1, 1'b1};
        vecs[4] = '{16'd2, 3'b011, 1'b0, 64'd90,                64'd100,               32'd2, 32'd2, 32'd0, 64'd90,                1'b0, 1'b1};
        vecs[5] = '{16'd1, 3'b000, 1'b0, 64'd87,                64'd100,               32'd0, 32'd0, 32'd0, 64'd87,                1'b0, 1'b0};
        vecs[6] = '{16'd5, 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 32'd5, 32'd0, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[7] = '{16'd2, 3'b000, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 32'd0, 32'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0};

        repeat (3) tick();
        checkReset("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], 1'b1, lat);
            exp_lat = ((vecs[i].win == 16'd0) ? 1 : int'(vecs[i].win)) + 3;
`ifdef POWER_THROTTLE_EN
            exp_thr = vecs[i].e_thr;
`else
            exp_thr = 1'b0;
`endif
            checkOutput($sformatf("v%0d latency", i), 64'(lat), 64'(exp_lat));
            checkOutput($sformatf("v%0d fsm_count", i), 64'(fsm_transition_count), 64'(vecs[i].e_fsm));
            checkOutput($sformatf("v%0d pcw_count", i), 64'(pcwrite_toggle_count), 64'(vecs[i].e_pcw));
            checkOutput($sformatf("v%0d rec_count", i), 64'(recovery_cycle_count), 64'(vecs[i].e_rec));
            checkOutput($sformatf("v%0d rpt_estimate", i), rpt_estimate, vecs[i].e_est);
            checkOutput($sformatf("v%0d rpt_over", i), 64'(rpt_over), 64'(vecs[i].e_over));
            checkOutput($sformatf("v%0d throttle", i), 64'(throttle), 64'(exp_thr));
            tick();
            checkOutput($sformatf("v%0d rpt_valid after handshake", i), 64'(rpt_valid), 64'd0);
            tick();
            checkOutput($sformatf("v%0d fsm_count held in idle", i), 64'(fsm_transition_count), 64'(vecs[i].e_fsm));
        end

        // Back-pressure: report must stay put while events and estimate keep moving.
        s = '{16'd2, 3'b001, 1'b0, 64'd77, 64'd100, 32'd2, 32'd0, 32'd0, 64'd77, 1'b0, 1'b0};
        applyStimulus(s, 1'b0, lat);
        checkOutput("stall latency", 64'(lat), 64'd5);
        for (int k = 0; k < 10; k++) begin
            evts      = 3'(k) ^ 3'b111;
            fixed_est = 64'(999 + k);
            tick();
            checkOutput($sformatf("stall%0d rpt_valid", k), 64'(rpt_valid), 64'd1);
            checkOutput($sformatf("stall%0d rpt_estimate", k), rpt_estimate, 64'd77);
            checkOutput($sformatf("stall%0d pcw_count", k), 64'(pcwrite_toggle_count), 64'd0);
            checkOutput($sformatf("stall%0d fsm_count", k), 64'(fsm_transition_count), 64'd2);
        end

        window_len = 16'd6;
        evts       = 3'b001;
        enable     = 1'b1;
        rpt_ready  = 1'b1;
        tick();
        checkOutput("restart rpt_valid", 64'(rpt_valid), 64'd0);
        checkOutput("restart fsm_count cleared", 64'(fsm_transition_count), 64'd0);
        rpt_ready = 1'b0;
        enable    = 1'b0;
        tick();
        checkOutput("restart fsm_count 1", 64'(fsm_transition_count), 64'd1);
        tick();
        checkOutput("restart fsm_count 2", 64'(fsm_transition_count), 64'd2);

        // Asynchronous reset in the middle of the window discards it.
        #2 reset = 1'b1;
        #1 checkReset("midreset");
        tick();
        reset = 1'b0;
        seen  = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (rpt_valid) seen++;
        end
        checkOutput("no report after reset", 64'(seen), 64'd0);
        checkOutput("fsm_count idle after reset", 64'(fsm_transition_count), 64'd0);

        s = '{16'd1, 3'b010, 1'b0, 64'd3, 64'd100, 32'd0, 32'd1, 32'd0, 64'd3, 1'b0, 1'b0};
        applyStimulus(s, 1'b1, lat);
        checkOutput("post-reset latency", 64'(lat), 64'd4);
        checkOutput("post-reset pcw_count", 64'(pcwrite_toggle_count), 64'd1);
        checkOutput("post-reset fsm_count", 64'(fsm_transition_count), 64'd0);
        checkOutput("post-reset rpt_estimate", rpt_estimate, 64'd3);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
